// File: rtl/xmit_readout_sequencer.sv
// Transmit-path frame readout sequencer.
// Polls enabled sources in index order and wraps their blocks in header/trailer words.
module xmit_readout_sequencer #(
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk128,
    input  logic              init,
    input  logic              trig,
    input  logic [NSRC-1:0]   enmask,
    input  logic [NSRC-1:0]   src_fst,
    input  logic [NSRC-1:0]   src_lst,
    input  logic [NSRC-1:0]   src_dav,
    input  logic [32*NSRC-1:0] src_dat,
    output logic [NSRC-1:0]   src_req,
    output logic              busy,
    output logic              trig_lost,
    output logic              fsto,
    output logic              lsto,
    output logic              davo,
    output logic [31:0]       dato
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HDR, GRANT, NEXT, TRL} state_t;

    state_t          state;
    logic [NSRC-1:0] emask;
    logic [NSRC-1:0] tflag;
    logic [SW-1:0]   sel;
    logic [15:0]     idle_cnt;
    logic [15:0]     frame_cnt;
    logic [15:0]     word_cnt;

    logic            g_dav;
    logic            g_lst;
    logic [31:0]     g_dat;
    logic            first_hit;
    logic [SW-1:0]   first_idx;
    logic            next_hit;
    logic [SW-1:0]   next_idx;

    // First-word flags carry no information the sequencer needs.
    logic unused_fst;
    assign unused_fst = ^src_fst;

    function automatic logic [7:0] pad8(input logic [NSRC-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NSRC-1:0] = v;
        return r;
    endfunction

    // Granted-source mux and lowest/next-higher enabled index search.
    always_comb begin
        g_dav     = 1'b0;
        g_lst     = 1'b0;
        g_dat     = '0;
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (sel == SW'(i)) begin
                g_dav = src_dav[i];
                g_lst = src_lst[i];
                g_dat = src_dat[32*i +: 32];
            end
            if (emask[i]) begin
                first_hit = 1'b1;
                first_idx = SW'(i);
            end
            if (emask[i] && (SW'(i) > sel)) begin
                next_hit = 1'b1;
                next_idx = SW'(i);
            end
        end
    end

    // Frame sequencer; every output is registered here.
    always_ff @(posedge clk128) begin
        if (init) begin
            state     <= IDLE;
            emask     <= '0;
            tflag     <= '0;
            sel       <= '0;
            idle_cnt  <= '0;
            frame_cnt <= '0;
            word_cnt  <= '0;
            src_req   <= '0;
            busy      <= 1'b0;
            trig_lost <= 1'b0;
            fsto      <= 1'b0;
            lsto      <= 1'b0;
            davo      <= 1'b0;
            dato      <= '0;
        end else begin
            davo      <= 1'b0;
            fsto      <= 1'b0;
            lsto      <= 1'b0;
            src_req   <= '0;
            trig_lost <= trig && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        emask <= enmask;
                        busy  <= 1'b1;
                        davo  <= 1'b1;
                        fsto  <= 1'b1;
                        dato  <= {8'hF0, pad8(enmask), frame_cnt};
                        state <= HDR;
                    end
                end
                HDR, NEXT: begin
                    if ((state == HDR) ? first_hit : next_hit) begin
                        sel      <= (state == HDR) ? first_idx : next_idx;
                        src_req  <= NSRC'(1) << ((state == HDR) ? first_idx : next_idx);
                        idle_cnt <= '0;
                        state    <= GRANT;
                    end else begin
                        davo  <= 1'b1;
                        lsto  <= 1'b1;
                        dato  <= {8'hE0, pad8(tflag), word_cnt};
                        state <= TRL;
                    end
                end
                GRANT: begin
                    if (g_dav) begin
                        davo     <= 1'b1;
                        dato     <= g_dat;
                        idle_cnt <= '0;
                        if (word_cnt != 16'hFFFF) begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                        if (g_lst) begin
                            state <= NEXT;
                        end
                    end else if (idle_cnt == TLIM) begin
                        tflag[sel] <= 1'b1;
                        state      <= NEXT;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                TRL: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    word_cnt  <= '0;
                    tflag     <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xmit_readout_sequencer.sv
// Scoreboard bench for xmit_readout_sequencer.
// Frame model builds the expected word list per trigger; monitor pops on davo.
module tb_xmit_readout_sequencer;

    localparam int NSRC = 4;
    localparam int TO   = 16;

    logic              clk128 = 1'b0;
    logic              init;
    logic              trig;
    logic [NSRC-1:0]   enmask;
    logic [NSRC-1:0]   src_fst;
    logic [NSRC-1:0]   src_lst;
    logic [NSRC-1:0]   src_dav;
    logic [32*NSRC-1:0] src_dat;
    logic [NSRC-1:0]   src_req;
    logic              busy;
    logic              trig_lost;
    logic              fsto;
    logic              lsto;
    logic              davo;
    logic [31:0]       dato;

    always #5 clk128 = ~clk128;

    xmit_readout_sequencer #(.NSRC(NSRC), .TIMEOUT(TO)) dut (
        .clk128(clk128), .init(init), .trig(trig), .enmask(enmask),
        .src_fst(src_fst), .src_lst(src_lst), .src_dav(src_dav),
        .src_dat(src_dat), .src_req(src_req), .busy(busy),
        .trig_lost(trig_lost), .fsto(fsto), .lsto(lsto),
        .davo(davo), .dato(dato)
    );

    int checks = 0;
    int failures = 0;
    logic [33:0] sb[$];
    int cfg_n[NSRC];
    bit garb = 1'b0;
    bit fast = 1'b0;
    int cur_seq = 0;
    logic [15:0] exp_fc = 16'h0;
    int cyc = 0;
    int req_cyc[NSRC];
    logic [NSRC-1:0] req_seen;
    int req_pulses = 0;
    int lost_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] word_of(input int i, input int k);
        return {4'hA, 4'(i), 8'(cur_seq), 16'(k)};
    endfunction

    // Reference: whole frame content from mask and per-source word counts.
    task automatic push_frame(input logic [NSRC-1:0] m);
        int cnt;
        logic [7:0] tf;
        cnt = 0;
        tf = '0;
        sb.push_back({2'b10, 8'hF0, 8'(m), exp_fc});
        for (int i = 0; i < NSRC; i++) begin
            if (m[i]) begin
                if (cfg_n[i] == 0) tf[i] = 1'b1;
                for (int k = 0; k < cfg_n[i]; k++) sb.push_back({2'b00, word_of(i, k)});
                cnt += cfg_n[i];
            end
        end
        sb.push_back({2'b01, 8'hE0, tf, (cnt > 65535) ? 16'hFFFF : 16'(cnt)});
        exp_fc = exp_fc + 16'd1;
    endtask

    initial forever begin
        @(posedge clk128);
        cyc++;
    end

    // Monitor: output words against scoreboard, plus request/lost bookkeeping.
    initial forever begin
        @(negedge clk128);
        if (davo) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected none", {fsto, lsto, dato});
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                chk("word", {30'd0, fsto, lsto, dato}, {30'd0, e});
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (src_req[i]) begin
                req_cyc[i] = cyc;
                req_seen[i] = 1'b1;
                req_pulses++;
            end
        end
        if (trig_lost) lost_cnt++;
    end

    // Source models: answer a request with cfg_n words, else optional garbage.
    initial begin
        bit act[NSRC];
        int rem[NSRC];
        int kk[NSRC];
        logic rs;
        src_dav = '0; src_lst = '0; src_fst = '0; src_dat = '0;
        for (int i = 0; i < NSRC; i++) begin act[i] = 0; rem[i] = 0; kk[i] = 0; end
        forever begin
            @(posedge clk128);
            rs = init;
            #1;
            for (int i = 0; i < NSRC; i++) begin
                src_dav[i] = 1'b0;
                src_lst[i] = 1'b0;
                src_fst[i] = 1'b0;
                if (rs) begin
                    act[i] = 0;
                    rem[i] = 0;
                    continue;
                end
                if (src_req[i]) begin
                    act[i] = 1;
                    rem[i] = cfg_n[i];
                    kk[i] = 0;
                end
                if (act[i]) begin
                    if (rem[i] > 0 && (fast || $urandom_range(0, 2) != 0)) begin
                        src_dav[i] = 1'b1;
                        src_dat[32*i +: 32] = word_of(i, kk[i]);
                        src_fst[i] = (kk[i] == 0);
                        src_lst[i] = (rem[i] == 1);
                        kk[i]++;
                        rem[i]--;
                        if (rem[i] == 0) act[i] = 0;
                    end
                end else if (garb && cfg_n[i] != 0 && $urandom_range(0, 3) == 0) begin
                    src_dav[i] = 1'b1;
                    src_lst[i] = 1'($urandom);
                    src_dat[32*i +: 32] = {16'hDEAD, 16'($urandom)};
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 70000) begin
            @(posedge clk128); #1;
            n++;
        end
        chk("frame_done_timeout", 64'(n >= 70000), 64'd0);
    endtask

    task automatic start_frame(input logic [NSRC-1:0] m);
        @(posedge clk128); #1;
        enmask = m;
        trig = 1'b1;
        cur_seq++;
        req_seen = '0;
        req_pulses = 0;
        push_frame(m);
        @(posedge clk128); #1;
        trig = 1'b0;
        enmask = 4'($urandom);
    endtask

    task automatic run_frame(input logic [NSRC-1:0] m);
        start_frame(m);
        wait_idle();
    endtask

    initial begin
        int n;
        int l0;
        init = 1'b1; trig = 1'b0; enmask = '0;
        for (int i = 0; i < NSRC; i++) begin cfg_n[i] = 0; req_cyc[i] = 0; end
        repeat (3) @(posedge clk128);
        #1;
        chk("reset_state", {src_req, busy, trig_lost, fsto, lsto, davo, dato}, 64'd0);
        init = 1'b0;

        // Empty mask with exact timing.
        @(posedge clk128); #1;
        enmask = '0; trig = 1'b1; cur_seq++; push_frame('0);
        @(posedge clk128); #1;
        trig = 1'b0;
        chk("empty_hdr", {davo, fsto, lsto, busy, dato}, {4'b1101, 32'hF0000000});
        @(posedge clk128); #1;
        chk("empty_trl", {davo, fsto, lsto, busy, dato}, {4'b1011, 32'hE0000000});
        @(posedge clk128); #1;
        chk("empty_busy_drop", {davo, busy}, 64'd0);
        run_frame('0);

        // Reset in the middle of a source-0 data word.
        cfg_n[0] = 8; cfg_n[1] = 2;
        start_frame(4'b0011);
        n = 0;
        while (!(davo && !fsto && !lsto) && n < 100) begin
            @(posedge clk128); #1;
            n++;
        end
        chk("reset_wait_data", 64'(n >= 100), 64'd0);
        init = 1'b1;
        @(posedge clk128); #1;
        chk("reset_midframe", {src_req, busy, trig_lost, fsto, lsto, davo, dato}, 64'd0);
        sb.delete();
        exp_fc = 16'h0;
        init = 1'b0;
        repeat (3) @(posedge clk128);

        // Two sources with garbage on an unselected one.
        cfg_n[0] = 3; cfg_n[1] = 5; cfg_n[2] = 2; cfg_n[3] = 0;
        garb = 1'b1;
        run_frame(4'b0101);
        chk("two_src_req_bits", 64'(req_seen), 64'h5);
        chk("two_src_req_pulses", 64'(req_pulses), 64'd2);

        // Timeout on a silent source 0.
        cfg_n[0] = 0; cfg_n[1] = 1;
        run_frame(4'b0011);
        chk("timeout_gap", 64'(req_cyc[1] - req_cyc[0]), 64'(TO + 1));

        // Trigger while busy: mid-frame and on the trailer cycle.
        cfg_n[0] = 6; cfg_n[1] = 3;
        l0 = lost_cnt;
        start_frame(4'b0011);
        repeat (2) @(posedge clk128);
        #1;
        trig = 1'b1;
        @(posedge clk128); #1;
        trig = 1'b0;
        n = 0;
        while (!(davo && lsto) && n < 200) begin
            @(posedge clk128); #1;
            n++;
        end
        chk("lost_wait_trl", 64'(n >= 200), 64'd0);
        trig = 1'b1;
        @(posedge clk128); #1;
        trig = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk128);
        #1;
        chk("trig_lost_count", 64'(lost_cnt - l0), 64'd2);
        run_frame('0);

        // Randomized frames.
        repeat (8) begin
            for (int i = 0; i < NSRC; i++) cfg_n[i] = $urandom_range(0, 5);
            run_frame(4'($urandom));
        end

        // Frame counter wrap.
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk128); #1;
        release dut.frame_cnt;
        exp_fc = 16'hFFFF;
        run_frame('0);
        run_frame('0);

        // Word count saturation.
        garb = 1'b0;
        fast = 1'b1;
        cfg_n[0] = 65540; cfg_n[1] = 0; cfg_n[2] = 0; cfg_n[3] = 0;
        run_frame(4'b0001);
        fast = 1'b0;

        repeat (3) @(posedge clk128);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
